// File: rtl/approx_mult_pkg.sv
// approx_mult_pkg: shared definitions for the sequential approximate multiplier.
//   state_t        - controller states IDLE/RUN/DONE
//   core_sel_t     - 4x4 core choice: exact, R1 or R2
//   MODE_*_BIT     - bit positions inside the 2-bit mode input
//   nib_count()    - number of 4-bit nibbles in an operand
//   mul2x2_approx  - 2x2 building block of the approximate cores (3*3 -> 7)
package approx_mult_pkg;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    typedef enum logic [1:0] {SEL_EXACT, SEL_R1, SEL_R2} core_sel_t;

    localparam int MODE_APPROX_BIT = 0;
    localparam int MODE_OR_BIT     = 1;

    function automatic int nib_count(input int width);
        return width / 4;
    endfunction

    // 3*3 = 9 needs a fourth output bit; reporting 7 keeps the product in three bits
    function automatic logic [3:0] mul2x2_approx(input logic [1:0] x, input logic [1:0] y);
        return (x == 2'd3 && y == 2'd3) ? 4'd7 : {2'b00, x} * {2'b00, y};
    endfunction

endpackage

// File: rtl/R1_4x4_mul.sv
// R1_4x4_mul: 4x4 approximate multiplier, only the low x low 2x2 block is approximate.
//   a, b - 4-bit unsigned operands
//   p    - 8-bit product
module R1_4x4_mul
    import approx_mult_pkg::*;
(
    input  logic [3:0] a,
    input  logic [3:0] b,
    output logic [7:0] p
);

    logic [3:0] ll, lh, hl, hh;

    always_comb begin
        ll = mul2x2_approx(a[1:0], b[1:0]);
        lh = {2'b00, a[1:0]} * {2'b00, b[3:2]};
        hl = {2'b00, a[3:2]} * {2'b00, b[1:0]};
        hh = {2'b00, a[3:2]} * {2'b00, b[3:2]};
        p  = 8'(ll) + (8'(lh) << 2) + (8'(hl) << 2) + (8'(hh) << 4);
    end

endmodule

// File: rtl/R2_4x4_mul.sv
// R2_4x4_mul: 4x4 approximate multiplier built from four approximate 2x2 blocks.
//   a, b - 4-bit unsigned operands
//   p    - 8-bit product
module R2_4x4_mul
    import approx_mult_pkg::*;
(
    input  logic [3:0] a,
    input  logic [3:0] b,
    output logic [7:0] p
);

    logic [3:0] ll, lh, hl, hh;

    always_comb begin
        ll = mul2x2_approx(a[1:0], b[1:0]);
        lh = mul2x2_approx(a[1:0], b[3:2]);
        hl = mul2x2_approx(a[3:2], b[1:0]);
        hh = mul2x2_approx(a[3:2], b[3:2]);
        p  = 8'(ll) + (8'(lh) << 2) + (8'(hl) << 2) + (8'(hh) << 4);
    end

endmodule

// File: rtl/mul4x4_sel.sv
// mul4x4_sel: 4x4 multiplier with selectable core (exact, R1 or R2).
//   a, b - 4-bit unsigned operands
//   sel  - core select, encoded as core_sel_t (unused code 3 falls back to exact)
//   p    - 8-bit product of the selected core
module mul4x4_sel
    import approx_mult_pkg::*;
(
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic [1:0] sel,
    output logic [7:0] p
);

    logic [7:0] p_r1, p_r2, p_ex;

    R1_4x4_mul u_r1 (.a(a), .b(b), .p(p_r1));
    R2_4x4_mul u_r2 (.a(a), .b(b), .p(p_r2));

    assign p_ex = {4'b0000, a} * {4'b0000, b};
    assign p    = (sel == SEL_R2) ? p_r2 : (sel == SEL_R1) ? p_r1 : p_ex;

endmodule

// File: rtl/approx_mult_seq.sv
// approx_mult_seq: sequential WIDTH x WIDTH multiplier, one 4x4 partial product per clock.
//   clk, rst             - clock, asynchronous active-high reset
//   in_valid / in_ready  - operand handshake (A, B, mode latched on acceptance)
//   mode[0]              - approximate cores (R2 on block (0,0), R1 elsewhere)
//   mode[1]              - OR-merge the low OR_COLS result columns
//   out_valid / out_ready- result handshake, R held stable while stalled
//   R                    - 2*WIDTH-bit product
module approx_mult_seq
    import approx_mult_pkg::*;
#(
    parameter int WIDTH   = 8,
    parameter int OR_COLS = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   A,
    input  logic [WIDTH-1:0]   B,
    input  logic [1:0]         mode,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] R
);

    localparam int N  = nib_count(WIDTH);
    localparam int IW = (N > 1) ? $clog2(N) : 1;
    localparam int RW = 2 * WIDTH;
    localparam logic [RW-1:0] OR_MASK = {RW{1'b1}} >> (RW - OR_COLS);

    state_t          state;
    logic [WIDTH-1:0] a_q, b_q;
    logic [1:0]      mode_q;
    logic [IW-1:0]   i_idx, j_idx;
    logic [RW-1:0]   acc;

    logic [3:0]      a_nib, b_nib;
    logic [1:0]      sel;
    logic [7:0]      p;
    logic [RW-1:0]   pp, lmask, acc_next;
    logic            last;

    mul4x4_sel u_core (.a(a_nib), .b(b_nib), .sel(sel), .p(p));

    // Both addends are masked to zero below column L, so the sum cannot
    // carry out of the OR region and the low sum bits stay zero.
    always_comb begin
        a_nib    = a_q[4*i_idx +: 4];
        b_nib    = b_q[4*j_idx +: 4];
        sel      = !mode_q[MODE_APPROX_BIT] ? SEL_EXACT :
                   (i_idx == '0 && j_idx == '0) ? SEL_R2 : SEL_R1;
        pp       = RW'(p) << (4 * (i_idx + j_idx));
        lmask    = mode_q[MODE_OR_BIT] ? OR_MASK : '0;
        acc_next = ((acc | pp) & lmask) | ((acc & ~lmask) + (pp & ~lmask));
        last     = (i_idx == IW'(N - 1)) && (j_idx == IW'(N - 1));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            acc       <= '0;
            i_idx     <= '0;
            j_idx     <= '0;
            a_q       <= '0;
            b_q       <= '0;
            mode_q    <= '0;
        end else begin
            case (state)
                IDLE: if (in_valid) begin
                    a_q      <= A;
                    b_q      <= B;
                    mode_q   <= mode;
                    acc      <= '0;
                    i_idx    <= '0;
                    j_idx    <= '0;
                    in_ready <= 1'b0;
                    state    <= RUN;
                end
                RUN: begin
                    acc <= acc_next;
                    if (j_idx == IW'(N - 1)) begin
                        j_idx <= '0;
                        i_idx <= i_idx + 1'b1;
                    end else begin
                        j_idx <= j_idx + 1'b1;
                    end
                    if (last) begin
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end
                end
                DONE: if (out_ready) begin
                    out_valid <= 1'b0;
                    in_ready  <= 1'b1;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign R = acc;

endmodule
